// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL supervisor and per-domain reset sequencer.
// Holds the PLL in reset, waits for a synchronised lock, and checks that lock stays stable.
// It then releases domain resets in ascending order, a fixed stagger apart.
// Lock loss or a relock request restarts the whole sequence.
// Optional feature macro: PLL_LOCK_TIMEOUT_EN enables the WAIT_LOCK timeout, retry_cnt and fault.
// Without it, WAIT_LOCK waits forever and retry_cnt/fault read as zero.
module pll_lock_sequencer #(
    parameter int unsigned NUM_CLOCKS          = 4,
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES      = 8,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic [NUM_CLOCKS-1:0] domain_rst_n,
    output logic                  ready,
    output logic [3:0]            retry_cnt,
    output logic                  fault
);

    localparam int unsigned HoldW  = $clog2(RST_HOLD_CYCLES + 1);
    localparam int unsigned StabW  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned StagW  = $clog2(STAGGER_CYCLES + 1);
    // The sample that moves WAIT_LOCK into STABLE is the first locked cycle, so STABLE
    // needs LOCK_STABLE_CYCLES-1 further locked samples before releasing.
    localparam int unsigned StableLast = (LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD_CYCLES - 1);
    localparam logic [StabW-1:0] StabLast = StabW'(StableLast);
    localparam logic [StagW-1:0] StagLast = StagW'(STAGGER_CYCLES - 1);
    localparam logic [NUM_CLOCKS-1:0] FirstDomain = NUM_CLOCKS'(1);

    typedef enum logic [2:0] {
        StPllReset,
        StWaitLock,
        StStable,
        StRelease,
        StRun
    } state_t;

    state_t                state_q, state_d;
    logic                  lk_meta_q, lk_s_q;
    logic                  req_q;
    logic [HoldW-1:0]      hold_q, hold_d;
    logic [StabW-1:0]      stab_q, stab_d;
    logic [StagW-1:0]      stag_q, stag_d;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_CLOCKS-1:0] drn_q, drn_d;
    logic [NUM_CLOCKS-1:0] drn_shift;
    logic                  ready_q, ready_d;
    logic                  restart;
    logic                  enter_release;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);

    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        retry_q, retry_d;
    logic              fault_q, fault_d;
`endif

    // Two-flop lock synchroniser; relock_req gets one register stage before the FSM.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_s_q    <= lk_meta_q;
            req_q     <= relock_req;
        end
    end

    // Released domains form a thermometer code, so the next release shifts in a one.
    assign drn_shift = (drn_q << 1) | FirstDomain;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        stab_d        = stab_q;
        stag_d        = stag_q;
        pll_rst_d     = pll_rst_q;
        drn_d         = drn_q;
        ready_d       = ready_q;
        restart       = 1'b0;
        enter_release = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
        timer_d       = timer_q;
        retry_d       = retry_q;
        fault_d       = fault_q;
`endif

        unique case (state_q)
            StPllReset: begin
                // relock_req is deliberately ignored here; the hold always completes.
                if (hold_q == HoldLast) begin
                    state_d   = StWaitLock;
                    hold_d    = '0;
                    pll_rst_d = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
                    timer_d   = '0;
`endif
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (req_q) begin
                    restart = 1'b1;
                end else if (lk_s_q) begin
                    if (LOCK_STABLE_CYCLES == 1) begin
                        enter_release = 1'b1;
                    end else begin
                        state_d = StStable;
                        stab_d  = '0;
                    end
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                else if (timer_q == TimerLast) begin
                    restart = 1'b1;
                    retry_d = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
                    fault_d = fault_q | (retry_d == 4'd15);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            StStable: begin
                if (req_q) begin
                    restart = 1'b1;
                end else if (!lk_s_q) begin
                    // A lock glitch only restarts the stability window, not the PLL.
                    state_d = StWaitLock;
`ifdef PLL_LOCK_TIMEOUT_EN
                    timer_d = '0;
`endif
                end else if (stab_q == StabLast) begin
                    enter_release = 1'b1;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            StRelease: begin
                if (!lk_s_q || req_q) begin
                    restart = 1'b1;
                end else if (stag_q == StagLast) begin
                    stag_d = '0;
                    drn_d  = drn_shift;
                    if (drn_shift[NUM_CLOCKS-1]) begin
                        state_d = StRun;
                        ready_d = 1'b1;
                    end
                end else begin
                    stag_d = stag_q + 1'b1;
                end
            end
            StRun: begin
                if (!lk_s_q || req_q) begin
                    restart = 1'b1;
                end
            end
            default: begin
                restart = 1'b1;
            end
        endcase

        if (enter_release) begin
            drn_d  = FirstDomain;
            stag_d = '0;
            if (NUM_CLOCKS == 1) begin
                state_d = StRun;
                ready_d = 1'b1;
            end else begin
                state_d = StRelease;
            end
        end

        if (restart) begin
            state_d   = StPllReset;
            hold_d    = '0;
            pll_rst_d = 1'b1;
            drn_d     = '0;
            ready_d   = 1'b0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StPllReset;
            hold_q    <= '0;
            stab_q    <= '0;
            stag_q    <= '0;
            pll_rst_q <= 1'b1;
            drn_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stab_q    <= stab_d;
            stag_q    <= stag_d;
            pll_rst_q <= pll_rst_d;
            drn_q     <= drn_d;
            ready_q   <= ready_d;
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    // Lock-timeout timer and sticky retry/fault bookkeeping.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            retry_q <= 4'd0;
            fault_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            retry_q <= retry_d;
            fault_q <= fault_d;
        end
    end

    assign retry_cnt = retry_q;
    assign fault     = fault_q;
`else
    assign retry_cnt = 4'd0;
    assign fault     = 1'b0;
`endif

    assign pll_rst      = pll_rst_q;
    assign domain_rst_n = drn_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: scoreboard bench for pll_lock_sequencer.
// Each scenario pushes its expected output timeline and checks it cycle by cycle.
// Honours PLL_LOCK_TIMEOUT_EN for the timeout-related expectations.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic [3:0] domain_rst_n;
    logic       ready;
    logic [3:0] retry_cnt;
    logic       fault;

    // Observed vector: {pll_rst, domain_rst_n[3:0], ready, retry_cnt[3:0], fault}
    logic [10:0] obs;
    assign obs = {pll_rst, domain_rst_n, ready, retry_cnt, fault};

    localparam logic [10:0] RstVec = 11'b1_0000_0_0000_0;

    typedef struct {
        int          at;
        string       name;
        logic [10:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    pll_lock_sequencer #(
        .NUM_CLOCKS         (4),
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .STAGGER_CYCLES     (2),
        .LOCK_TIMEOUT_CYCLES(32)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .domain_rst_n(domain_rst_n),
        .ready       (ready),
        .retry_cnt   (retry_cnt),
        .fault       (fault)
    );

    always #5 refclk = ~refclk;

    // Expected outputs after edge c, for a restart at edge r and domain 0 released at edge rel.
    function automatic logic [10:0] exp_vec(int c, int r, int rel, logic [3:0] rc, logic f);
        logic [3:0] d;
        logic       pr;
        logic       rdy;
        pr = (c >= r) && (c < r + 4);
        for (int i = 0; i < 4; i++) d[i] = (c >= rel + 2 * i);
        rdy = (c >= rel + 6);
        return {pr, d, rdy, rc, f};
    endfunction

    task automatic push_win(input string nm, input int from, input int to, input int r,
                            input int rel, input logic [3:0] rc, input logic f);
        exp_t e;
        for (int c = from; c <= to; c++) begin
            e.at   = c;
            e.name = nm;
            e.val  = exp_vec(c, r, rel, rc, f);
            sb.push_back(e);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(posedge refclk);
        cyc++;
        @(negedge refclk);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(negedge refclk);
        e.at = 0; e.name = "reset_hold"; e.val = RstVec;
        sb.push_back(e);
        e = sb.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.name, obs, e.val);
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // pll_locked rises 10 cycles after pll_rst falls; domains release 2 apart.
    task automatic test_cold_start();
        exp_t e;
        push_win("cold_start", 1, 31, 0, 24, 4'd0, 1'b0);
        while (cyc < 31) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s @%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
            if (cyc == 14) pll_locked = 1'b1;
        end
    endtask

    // Lock drops before edge 36: restart visible after edge 38, then full re-sequence.
    task automatic test_lock_loss();
        exp_t e;
        push_win("lock_loss_run", 32, 37, 0, 24, 4'd0, 1'b0);
        push_win("lock_loss_restart", 38, 61, 38, 54, 4'd0, 1'b0);
        while (cyc < 61) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s @%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
            if (cyc == 35) pll_locked = 1'b0;
            if (cyc == 44) pll_locked = 1'b1;
        end
    endtask

    // relock_req sampled at edge 64 restarts at 65; a second pulse inside PLL_RESET is ignored.
    task automatic test_relock();
        exp_t e;
        push_win("relock_run", 62, 64, 38, 54, 4'd0, 1'b0);
        push_win("relock_restart", 65, 83, 65, 77, 4'd0, 1'b0);
        while (cyc < 83) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s @%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
            relock_req = (cyc == 63) || (cyc == 67);
        end
    endtask

    // One-cycle lock glitch at STABLE count 5 restarts the stability window.
    task automatic test_glitch();
        exp_t e;
        push_win("glitch_run", 84, 85, 65, 77, 4'd0, 1'b0);
        push_win("glitch_seq", 86, 112, 86, 105, 4'd0, 1'b0);
        while (cyc < 112) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s @%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
            relock_req = (cyc == 84);
            if (cyc == 94) pll_locked = 1'b0;
            if (cyc == 95) pll_locked = 1'b1;
        end
    endtask

    // Lock never returns: retries every 36 cycles, saturating at 15 with fault.
    task automatic test_timeout();
        exp_t e;
        int   n;
        pll_locked = 1'b0;
        for (int c = 113; c <= 700; c++) begin
            e.at   = c;
            e.name = "timeout";
            if (c < 115) begin
                e.val = exp_vec(c, 86, 105, 4'd0, 1'b0);
            end else begin
`ifdef PLL_LOCK_TIMEOUT_EN
                n     = (c - 115) / 36;
                e.val = {((c - 115) % 36) < 4, 4'b0000, 1'b0,
                         (n > 15) ? 4'd15 : 4'(n), n >= 15};
`else
                n     = 0;
                e.val = {c < 119, 4'b0000, 1'b0, 4'(n), 1'b0};
`endif
            end
            sb.push_back(e);
        end
        while (cyc < 700) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s @%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    // Lock returns, then rst_n is asserted mid-release with domain_rst_n=0011.
    task automatic test_async_reset();
        exp_t e;
        logic [3:0] rc;
        logic f;
`ifdef PLL_LOCK_TIMEOUT_EN
        rc = 4'd15; f = 1'b1;
`else
        rc = 4'd0;  f = 1'b0;
`endif
        pll_locked = 1'b1;
        push_win("mid_release", 701, 712, 0, 710, rc, f);
        while (cyc < 712) begin
            tick();
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s @%0d got=%b want=%b", e.name, cyc, obs, e.val);
                end
            end
        end
        rst_n = 1'b0;
        #1;
        e.at = cyc; e.name = "async_reset"; e.val = RstVec;
        sb.push_back(e);
        e = sb.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.name, obs, e.val);
        end
        repeat (2) @(negedge refclk);
        e.at = cyc; e.name = "reset_held"; e.val = RstVec;
        sb.push_back(e);
        e = sb.pop_front();
        total++;
        if (obs !== e.val) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.name, obs, e.val);
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_lock_loss();
        test_relock();
        test_glitch();
        test_timeout();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
